find_max_sequencer: RTL and testbench

FIND_MAX_SEQUENCER -- requirements
Module: find_max_sequencer

---
 rtl/find_max_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_find_max_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/find_max_sequencer.sv
// Command FIFO plus Moore sequencer that feeds operand pairs to find_MAX
// and returns its result (or a timeout) to the host.
package find_max_pkg;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] instr;
    logic [7:0] gap;
    logic       last;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    HEAD,
    ONE_LEFT,
    GAP,
    SEND,
    WAIT_FIN
  } state_t;
endpackage

module find_max_sequencer
  import find_max_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [2:0] cmd_instr,
  input  logic [7:0] cmd_gap,
  input  logic       cmd_last,
  output logic       start,
  output logic       valid,
  output logic [7:0] Data_A,
  output logic [7:0] Data_B,
  output logic [2:0] instruction,
  output logic       one_left,
  input  logic       finish,
  input  logic [7:0] maximum,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       err_timeout
);

  cmd_t       mem [4];
  logic [1:0] wr_q;
  logic [1:0] rd_q;
  logic [2:0] cnt_q;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  cmd_t       head;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] gap_q;
  logic [7:0] gap_d;
  logic [9:0] wcnt_q;
  logic [9:0] wcnt_d;
  logic       res_valid_q;
  logic       res_valid_d;
  logic       err_q;
  logic       err_d;
  logic [7:0] res_data_q;
  logic [7:0] res_data_d;

  assign full      = (cnt_q == 3'd4);
  assign empty     = (cnt_q == 3'd0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem[wr_q] <= '{a: cmd_a, b: cmd_b,
                       instr: cmd_instr,
                       gap: cmd_gap,
                       last: cmd_last};
        wr_q      <= wr_q + 2'd1;
      end
      if (pop) begin
        rd_q <= rd_q + 2'd1;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      wcnt_q      <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      wcnt_q      <= wcnt_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      res_data_q  <= res_data_d;
    end
  end

  // gap_q holds the idle cycles still owed before SEND
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    wcnt_d      = wcnt_q;
    pop         = 1'b0;
    res_valid_d = 1'b0;
    err_d       = 1'b0;
    res_data_d  = res_data_q;
    unique case (state_q)
      IDLE: begin
        wcnt_d = '0;
        if (!empty && !finish) begin
          state_d = START;
        end
      end
      START: begin
        state_d = HEAD;
      end
      HEAD: begin
        if (!empty) begin
          gap_d = head.gap;
          if (head.last) begin
            state_d = ONE_LEFT;
          end else if (head.gap == 8'd0) begin
            state_d = SEND;
          end else begin
            state_d = GAP;
          end
        end
      end
      ONE_LEFT: begin
        if (gap_q == 8'd0) begin
          state_d = SEND;
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        gap_d = gap_q - 8'd1;
        if (gap_q == 8'd1) begin
          state_d = SEND;
        end
      end
      SEND: begin
        pop    = 1'b1;
        wcnt_d = '0;
        if (head.last) begin
          state_d = WAIT_FIN;
        end else begin
          state_d = HEAD;
        end
      end
      WAIT_FIN: begin
        if (finish) begin
          res_data_d  = maximum;
          res_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (wcnt_q == 10'd1023) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 10'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    start       = 1'b0;
    one_left    = 1'b0;
    valid       = 1'b0;
    Data_A      = '0;
    Data_B      = '0;
    instruction = '0;
    unique case (1'b1)
      (state_q == START):    start    = 1'b1;
      (state_q == ONE_LEFT): one_left = 1'b1;
      (state_q == SEND): begin
        valid       = 1'b1;
        Data_A      = head.a;
        Data_B      = head.b;
        instruction = head.instr;
      end
      default: ;
    endcase
  end

  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_find_max_sequencer.sv
// Directed bench for find_max_sequencer with a payload scoreboard
// and per-cycle output event logging.
module tb_find_max_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [2:0] cmd_instr;
  logic [7:0] cmd_gap;
  logic       cmd_last;
  logic       start;
  logic       valid;
  logic [7:0] Data_A;
  logic [7:0] Data_B;
  logic [2:0] instruction;
  logic       one_left;
  logic       finish;
  logic [7:0] maximum;
  logic       res_valid;
  logic [7:0] res_data;
  logic       err_timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [18:0] sb [$];
  int start_q [$];
  int ol_q [$];
  int valid_q [$];
  int resv_q [$];
  int err_q [$];

  find_max_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_a(cmd_a),
    .cmd_b(cmd_b),
    .cmd_instr(cmd_instr),
    .cmd_gap(cmd_gap),
    .cmd_last(cmd_last),
    .start(start),
    .valid(valid),
    .Data_A(Data_A),
    .Data_B(Data_B),
    .instruction(instruction),
    .one_left(one_left),
    .finish(finish),
    .maximum(maximum),
    .res_valid(res_valid),
    .res_data(res_data),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [18:0] e;
    chk("mutex", 32'(int'(start) + int'(one_left)
                    + int'(valid) <= 1), 1);
    if (!valid) begin
      chk("idle_payload", {Data_A, Data_B, instruction}, 0);
    end
    if (start) start_q.push_back(cyc);
    if (one_left) ol_q.push_back(cyc);
    if (res_valid) resv_q.push_back(cyc);
    if (err_timeout) err_q.push_back(cyc);
    if (valid) begin
      valid_q.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("payload", {Data_A, Data_B, instruction}, e);
      end
    end
  end

  function automatic int cnt_of(input int sel);
    case (sel)
      0:       return start_q.size();
      1:       return ol_q.size();
      2:       return valid_q.size();
      3:       return resv_q.size();
      default: return err_q.size();
    endcase
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    start_q.delete();
    ol_q.delete();
    valid_q.delete();
    resv_q.delete();
    err_q.delete();
  endtask

  task automatic wait_ev(input string tag, input int sel,
                         input int n, input int budget);
    for (int i = 0; i < budget && cnt_of(sel) < n; i++) begin
      step();
    end
    chk(tag, 32'(cnt_of(sel) >= n), 1);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] ins, input logic [7:0] gap,
                      input logic lst, input logic exp_ready);
    cmd_a     = a;
    cmd_b     = b;
    cmd_instr = ins;
    cmd_gap   = gap;
    cmd_last  = lst;
    cmd_valid = 1'b1;
    chk("cmd_ready", cmd_ready, exp_ready);
    if (exp_ready) sb.push_back({a, b, ins});
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {start, valid, one_left, res_valid, err_timeout,
              Data_A, Data_B, instruction}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int d;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_instr = '0;
    cmd_gap   = '0;
    cmd_last  = 1'b0;
    finish    = 1'b0;
    maximum   = '0;
    step(2);
    chk_quiet("reset_outputs");
    chk("reset_res_data", res_data, 0);
    chk("reset_ready", cmd_ready, 1);
    rst_n = 1'b1;
    step();

    // fill FIFO while finish holds the FSM in IDLE
    finish = 1'b1;
    push(8'h11, 8'h22, 3'd1, 8'd2, 1'b0, 1'b1);
    push(8'h33, 8'h44, 3'd2, 8'd2, 1'b0, 1'b1);
    push(8'h55, 8'h66, 3'd3, 8'd2, 1'b0, 1'b1);
    push(8'h77, 8'h88, 3'd4, 8'd2, 1'b1, 1'b1);
    chk("full_ready", cmd_ready, 0);
    push(8'h99, 8'hAA, 3'd5, 8'd0, 1'b1, 1'b0);
    step(3);
    chk("hold_idle_finish", 32'(start_q.size()), 0);

    clr();
    finish = 1'b0;
    wait_ev("four_valids", 2, 4, 60);
    chk("one_start", 32'(start_q.size()), 1);
    chk("one_oneleft", 32'(ol_q.size()), 1);
    if (start_q.size() == 1 && valid_q.size() >= 4
        && ol_q.size() == 1) begin
      s = start_q[0];
      chk("valid1_time", 32'(valid_q[0] - s), 4);
      chk("valid2_time", 32'(valid_q[1] - s), 8);
      chk("valid3_time", 32'(valid_q[2] - s), 12);
      chk("oneleft_time", 32'(ol_q[0] - s), 14);
      chk("valid4_time", 32'(valid_q[3] - s), 17);
    end

    step(4);
    finish  = 1'b1;
    maximum = 8'hA7;
    wait_ev("res_valid_seen", 3, 1, 20);
    chk("res_data", res_data, 8'hA7);
    step(3);
    chk("res_pulse_once", 32'(resv_q.size()), 1);
    chk("no_extra_valid", 32'(valid_q.size()), 4);
    chk("drained_ready", cmd_ready, 1);

    // single last pair, gap 0, held off until finish drops
    clr();
    push(8'hC3, 8'h3C, 3'd6, 8'd0, 1'b1, 1'b1);
    step(8);
    chk("no_start_finish_hi", 32'(start_q.size()), 0);
    finish  = 1'b0;
    maximum = 8'h55;
    wait_ev("single_valid", 2, 1, 20);
    if (start_q.size() == 1 && ol_q.size() == 1) begin
      s = start_q[0];
      chk("single_oneleft", 32'(ol_q[0] - s), 2);
      chk("single_valid_t", 32'(valid_q[0] - s), 3);
    end else begin
      chk("single_events", 0, 1);
    end

    wait_ev("timeout_seen", 4, 1, 1100);
    if (err_q.size() > 0) begin
      d = err_q[0] - valid_q[0];
      chk("timeout_latency", 32'(d >= 1023 && d <= 1025), 1);
    end
    step(3);
    chk("timeout_once", 32'(err_q.size()), 1);
    chk("timeout_no_res", 32'(resv_q.size()), 0);
    chk("timeout_res_kept", res_data, 8'hA7);

    // reset during the gap of pair 2
    clr();
    push(8'h01, 8'h02, 3'd1, 8'd3, 1'b0, 1'b1);
    push(8'h03, 8'h04, 3'd2, 8'd3, 1'b1, 1'b1);
    wait_ev("pair1_valid", 2, 1, 30);
    step(2);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_quiet("async_reset_out");
    chk("async_reset_res", res_data, 0);
    chk("async_reset_ready", cmd_ready, 1);
    step(2);
    rst_n = 1'b1;
    clr();
    step(10);
    chk("post_reset_start", 32'(start_q.size()), 0);
    chk("post_reset_valid", 32'(valid_q.size()), 0);
    chk("post_reset_ready", cmd_ready, 1);
    chk_quiet("post_reset_quiet");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
